// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, LED/switch registers and an optional
// compare timer, compiled in when DMEM_RESPONDER_TIMER_EN is defined.
module dmem_responder #(
  parameter int RAM_AW   = 8,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] dmem_addr,
  input  logic [31:0] dmem_data_out,
  input  logic        dmem_wr,
  output logic [31:0] dmem_data_in,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        irq
);

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_chk
    $error("PRESCALE out of range");
  end

  localparam int DEPTH = 1 << RAM_AW;

  logic [31:0] mem_q [DEPTH];
  logic [15:0] led_q;
  logic [15:0] sw1_q;
  logic [15:0] sw2_q;

  logic [RAM_AW-1:0] idx;
  logic sel_ram;
  logic sel_led;
  logic sel_sw;

  assign idx     = dmem_addr[RAM_AW-1:0];
  assign sel_ram = (dmem_addr >> RAM_AW) == 16'd0;
  assign sel_led = dmem_addr == 16'hFF00;
  assign sel_sw  = dmem_addr == 16'hFF01;

  // RAM has no reset; writes landing while reset is held are dropped.
  always_ff @(posedge clk) begin
    if (dmem_wr && sel_ram && !resetn)
      mem_q[idx] <= dmem_data_out;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      led_q <= '0;
      sw1_q <= '0;
      sw2_q <= '0;
    end else begin
      sw1_q <= sw_in;
      sw2_q <= sw1_q;
      if (dmem_wr && sel_led)
        led_q <= dmem_data_out[15:0];
    end
  end

  assign led_out = led_q;

`ifdef DMEM_RESPONDER_TIMER_EN
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic        sel_cnt;
  logic        sel_cmp;
  logic        sel_ctrl;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] cmp_q;
  logic [15:0] pre_q;
  logic [15:0] pre_d;
  logic        en_q;
  logic        auto_q;
  logic        flag_q;
  logic        flag_d;
  logic        ie_q;
  logic        tick;
  logic        match;
  logic        wr_cnt;
  logic        wr_ctrl;

  assign sel_cnt  = dmem_addr == 16'hFF02;
  assign sel_cmp  = dmem_addr == 16'hFF03;
  assign sel_ctrl = dmem_addr == 16'hFF04;
  assign wr_cnt   = dmem_wr && sel_cnt;
  assign wr_ctrl  = dmem_wr && sel_ctrl;
  assign tick     = en_q && (pre_q == PRE_MAX);
  assign match    = cnt_q == cmp_q;

  // CPU write to CNT beats the tick; FLAG set beats FLAG clear.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    pre_d  = '0;
    if (en_q && !tick)
      pre_d = pre_q + 16'd1;
    if (tick)
      cnt_d = (match && auto_q) ? 32'd0 : cnt_q + 32'd1;
    if (wr_cnt)
      cnt_d = dmem_data_out;
    if (wr_ctrl && dmem_data_out[2])
      flag_d = 1'b0;
    if (tick && match)
      flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt_q  <= '0;
      cmp_q  <= '0;
      pre_q  <= '0;
      en_q   <= 1'b0;
      auto_q <= 1'b0;
      flag_q <= 1'b0;
      ie_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      flag_q <= flag_d;
      if (dmem_wr && sel_cmp)
        cmp_q <= dmem_data_out;
      if (wr_ctrl) begin
        en_q   <= dmem_data_out[0];
        auto_q <= dmem_data_out[1];
        ie_q   <= dmem_data_out[3];
      end
    end
  end

  assign irq = flag_q & ie_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    dmem_data_in = '0;
    unique case (1'b1)
      sel_ram:  dmem_data_in = mem_q[idx];
      sel_led:  dmem_data_in = {16'h0, led_q};
      sel_sw:   dmem_data_in = {16'h0, sw2_q};
`ifdef DMEM_RESPONDER_TIMER_EN
      sel_cnt:  dmem_data_in = cnt_q;
      sel_cmp:  dmem_data_in = cmp_q;
      sel_ctrl: dmem_data_in = {28'h0, ie_q, flag_q, auto_q, en_q};
`endif
      default:  dmem_data_in = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; timer steps run only when
// DMEM_RESPONDER_TIMER_EN is defined.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_data_out;
  logic        dmem_wr;
  logic [31:0] dmem_data_in;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        irq;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.RAM_AW(8), .PRESCALE(1)) dut (
    .clk(clk),
    .resetn(resetn),
    .dmem_addr(dmem_addr),
    .dmem_data_out(dmem_data_out),
    .dmem_wr(dmem_wr),
    .dmem_data_in(dmem_data_in),
    .sw_in(sw_in),
    .led_out(led_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    dmem_addr     = a;
    dmem_data_out = d;
    dmem_wr       = 1'b1;
    cyc();
    dmem_wr       = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a,
                    input logic [31:0] exp);
    dmem_addr = a;
    #1;
    chk(tag, dmem_data_in, exp);
  endtask

  initial begin
    resetn        = 1'b1;
    dmem_addr     = '0;
    dmem_data_out = '0;
    dmem_wr       = 1'b0;
    sw_in         = '0;
    #3;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    cyc();
    cyc();
    resetn = 1'b0;

    // RAM round trip, same-cycle read-old, out-of-range
    wr(16'h0005, 32'h0BADF00D);
    dmem_addr     = 16'h0005;
    dmem_data_out = 32'hDEADBEEF;
    dmem_wr       = 1'b1;
    #1;
    chk("ram_rd_old", dmem_data_in, 32'h0BADF00D);
    cyc();
    dmem_wr = 1'b0;
    rd("ram5", 16'h0005, 32'hDEADBEEF);
    wr(16'h0006, 32'h12345678);
    rd("ram6", 16'h0006, 32'h12345678);
    wr(16'h0000, 32'hCAFE0001);
    wr(16'h0100, 32'h55555555);
    rd("ram100", 16'h0100, 32'h0);
    rd("ram0_noalias", 16'h0000, 32'hCAFE0001);
    wr(16'h0007, 32'h11111111);

    // LED and SW
    wr(16'hFF00, 32'hABCD1234);
    chk("led_out", 32'(led_out), 32'h1234);
    rd("led_rd", 16'hFF00, 32'h00001234);
    sw_in = 16'h00A5;
    rd("sw_edge0", 16'hFF01, 32'h0);
    cyc();
    rd("sw_edge1", 16'hFF01, 32'h0);
    cyc();
    rd("sw_edge2", 16'hFF01, 32'h000000A5);
    wr(16'hFF01, 32'hFFFFFFFF);
    rd("sw_wr_ign", 16'hFF01, 32'h000000A5);
    rd("unmap_ff05", 16'hFF05, 32'h0);

`ifdef DMEM_RESPONDER_TIMER_EN
    // Match without auto-reload
    wr(16'hFF03, 32'd3);
    wr(16'hFF04, 32'h9);
    rd("cnt0", 16'hFF02, 32'd0);
    cyc();
    rd("cnt1", 16'hFF02, 32'd1);
    cyc();
    rd("cnt2", 16'hFF02, 32'd2);
    cyc();
    rd("cnt3", 16'hFF02, 32'd3);
    chk("irq_pre", 32'(irq), 32'h0);
    cyc();
    rd("cnt4", 16'hFF02, 32'd4);
    rd("ctrl_flag", 16'hFF04, 32'hD);
    chk("irq_set", 32'(irq), 32'h1);
    wr(16'hFF04, 32'hD);
    chk("irq_clr", 32'(irq), 32'h0);
    rd("ctrl_clr", 16'hFF04, 32'h9);
    wr(16'hFF04, 32'h0);
    wr(16'hFF02, 32'h0);

    // Auto-reload
    wr(16'hFF03, 32'd2);
    wr(16'hFF04, 32'h3);
    rd("ar0", 16'hFF02, 32'd0);
    rd("ar_noflag", 16'hFF04, 32'h3);
    cyc();
    rd("ar1", 16'hFF02, 32'd1);
    cyc();
    rd("ar2", 16'hFF02, 32'd2);
    cyc();
    rd("ar0b", 16'hFF02, 32'd0);
    rd("ar_flag", 16'hFF04, 32'h7);
    cyc();
    rd("ar1b", 16'hFF02, 32'd1);
    cyc();
    rd("ar2b", 16'hFF02, 32'd2);
    wr(16'hFF02, 32'h10);
    rd("cnt_wr_prio", 16'hFF02, 32'h10);
    wr(16'hFF04, 32'h4);
    rd("ctrl_off", 16'hFF04, 32'h0);

    // Wrap and set/clear collision
    wr(16'hFF02, 32'hFFFFFFFF);
    wr(16'hFF03, 32'h0);
    wr(16'hFF04, 32'h1);
    rd("wrap_pre", 16'hFF02, 32'hFFFFFFFF);
    cyc();
    rd("wrap_cnt", 16'hFF02, 32'h0);
    rd("wrap_noflag", 16'hFF04, 32'h1);
    wr(16'hFF04, 32'h5);
    rd("coll_flag", 16'hFF04, 32'h5);
    rd("coll_cnt", 16'hFF02, 32'h1);
    chk("coll_irq_ie0", 32'(irq), 32'h0);

    // Running timer with IE set before reset
    wr(16'hFF00, 32'h0000FFFF);
    wr(16'hFF04, 32'hB);
    chk("irq_on", 32'(irq), 32'h1);
`else
    wr(16'hFF02, 32'h12345678);
    rd("nt_ff02", 16'hFF02, 32'h0);
    wr(16'hFF03, 32'h3);
    rd("nt_ff03", 16'hFF03, 32'h0);
    wr(16'hFF04, 32'hF);
    rd("nt_ff04", 16'hFF04, 32'h0);
    chk("nt_irq", 32'(irq), 32'h0);
    wr(16'hFF00, 32'h0000FFFF);
`endif

    // Reset mid-cycle with a write in flight
    chk("led_ffff", 32'(led_out), 32'hFFFF);
    dmem_addr     = 16'hFF00;
    dmem_data_out = 32'h00001234;
    dmem_wr       = 1'b1;
    #2;
    resetn = 1'b1;
    #1;
    chk("mrst_led", 32'(led_out), 32'h0);
    chk("mrst_irq", 32'(irq), 32'h0);
    dmem_addr = 16'hFF02;
    #1;
    chk("mrst_cnt", dmem_data_in, 32'h0);
    dmem_addr     = 16'h0007;
    dmem_data_out = 32'h22222222;
    cyc();
    dmem_wr = 1'b0;
    chk("mrst_led_edge", 32'(led_out), 32'h0);
    resetn = 1'b0;
    rd("ram_kept", 16'h0007, 32'h11111111);
    rd("mrst_sw", 16'hFF01, 32'h0);
    cyc();
    chk("post_led", 32'(led_out), 32'h0);
    chk("post_irq", 32'(irq), 32'h0);
    cyc();
    rd("post_sw", 16'hFF01, 32'h000000A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, meaning log2 of the RAM depth in 32-bit words.
REQ-002 SHALL have parameter PRESCALE, default 1, meaning clk cycles per timer tick (legal range 1..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous active-high reset (1 = reset).
REQ-005 SHALL have port dmem_addr, input, 16 bits: word address from the processor MEM stage.
REQ-006 SHALL have port dmem_data_out, input, 32 bits: processor write data.
REQ-007 SHALL have port dmem_wr, input, 1 bit: write strobe; 1 = write this cycle.
REQ-008 SHALL have port dmem_data_in, output, 32 bits: read data to the processor.
REQ-009 SHALL have port sw_in, input, 16 bits: asynchronous switch inputs.
REQ-010 SHALL have port led_out, output, 16 bits: LED register value.
REQ-011 SHALL have port irq, output, 1 bit: timer interrupt.

Function
REQ-012 SHALL decode the address map as follows: 0x0000..2^RAM_AW-1 RAM; 0xFF00 LED (RW, bits 15:0); 0xFF01 SW (RO); 0xFF02 CNT (RW); 0xFF03 CMP (RW); 0xFF04 CTRL (RW).
REQ-013 SHALL make dmem_data_in combinational from dmem_addr (zero-latency read), because the processor captures it in the same cycle.
REQ-014 SHALL commit writes at the rising edge in the dmem_wr=1 cycle; a same-cycle read returns the old value.
REQ-015 SHALL return 0 for reads of unmapped addresses and SHALL ignore writes to them; writes to SW SHALL be ignored.
REQ-016 SHALL zero-extend the LED and SW registers into bits 31:16 on read.
REQ-017 SHALL synchronise sw_in through 2 flops; SW reads return sw_in as sampled 2 edges earlier.
REQ-018 SHALL define CTRL bits as: bit0 EN, bit1 AUTO (auto-reload), bit2 FLAG (sticky; write 1 clears, write 0 no effect), bit3 IE; bits 31:4 SHALL read 0.
REQ-019 SHALL run a prescaler counting 0..PRESCALE-1 while EN=1; tick SHALL assert for one cycle at the wrap. Prescaler SHALL clear when EN=0.
REQ-020 SHALL evaluate CNT on a tick: if CNT==CMP then FLAG<=1 and CNT<=(AUTO ? 0 : CNT+1); otherwise CNT<=CNT+1. CNT SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 SHALL hold CNT while EN=0.
REQ-022 SHALL give a CPU write to CNT priority over a same-cycle tick update.
REQ-023 SHALL let set win when a FLAG set and a FLAG clear occur in the same cycle (FLAG stays 1).
REQ-024 SHALL drive irq = FLAG & IE, combinationally from registers.

Reset
REQ-025 SHALL clear LED, SW sync flops, CNT, CMP, CTRL and the prescaler to 0 immediately on resetn=1, independent of clk, so that led_out=0 and irq=0.
REQ-026 SHALL leave RAM contents unaffected by reset; RAM is undefined until written.
REQ-027 SHALL discard a write in progress when reset is asserted mid-cycle; no register SHALL update until the first edge after resetn=0.

Configuration
REQ-028 SHALL compile in the timer (prescaler, CNT, CMP, CTRL, irq logic) when macro DMEM_RESPONDER_TIMER_EN is defined.
REQ-029 SHALL, without DMEM_RESPONDER_TIMER_EN, decode 0xFF02..0xFF04 as unmapped (read 0, writes ignored), tie irq to 0, and generate no timer flops.

Verification
REQ-030 SHALL cover RAM round trip: write 0xDEADBEEF to 0x0005, then read 0x0005 -> 0xDEADBEEF; read 0x0006 after writing 0x12345678 there -> 0x12345678; read 0x0100 with RAM_AW=8 -> 0.
REQ-031 SHALL cover LED/SW: write 0xABCD1234 to 0xFF00 -> led_out=0x1234 and readback 0x00001234; set sw_in=0x00A5 -> SW read equals 0x000000A5 from the 2nd edge onward, old value before.
REQ-032 SHALL cover timer match with PRESCALE=1: CMP=3, CTRL=0x9 -> CNT reads 0,1,2,3 on successive cycles, then FLAG=1, irq=1, CNT=4; write CTRL=0xD -> irq=0.
REQ-033 SHALL cover auto-reload: CMP=2, CTRL=0x3 -> CNT sequence 0,1,2,0,1,2 with FLAG set at the first match; a CNT write of 0x10 in a tick cycle -> CNT reads 0x10 next cycle.
REQ-034 SHALL cover collision and wrap: CNT=0xFFFFFFFF, CMP=0 -> next tick gives CNT=0 with no flag, the following tick sets FLAG; a FLAG clear in the set cycle -> FLAG=1.
REQ-035 SHALL cover reset mid-operation: assert resetn with the timer running and LED=0xFFFF -> led_out=0, irq=0, CNT=0 before the next edge; build without the macro -> read 0xFF02 = 0 and irq constant 0.
